// File: rtl/pc_seq_unit.sv
// Fetch-stage programme counter with op-selected next-PC, stall, and a small
// return-address stack that raises sticky overflow/underflow/illegal-op flags.
module pc_seq_unit #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       STEP      = 1,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           offset,
  input  logic [WIDTH-1:0]           target,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_ill
);

  localparam int unsigned DW = $clog2(DEPTH+1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DW-1:0]    DEPTH_W = DW'(DEPTH);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

  localparam logic [2:0] OP_HOLD     = 3'b000;
  localparam logic [2:0] OP_INC      = 3'b001;
  localparam logic [2:0] OP_BRANCH   = 3'b010;
  localparam logic [2:0] OP_JUMP     = 3'b011;
  localparam logic [2:0] OP_CALL     = 3'b100;
  localparam logic [2:0] OP_RET      = 3'b101;
  localparam logic [2:0] OP_CALL_REL = 3'b110;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] stack_q [2**AW];

  logic             full, empty;
  logic             push_en;
  logic [AW-1:0]    push_idx, pop_idx;
  logic [DW-1:0]    depth_m1;
  logic [WIDTH-1:0] ret_addr;
  logic             ovf_set, unf_set, ill_set;

  assign full     = (depth_q == DEPTH_W);
  assign empty    = (depth_q == '0);
  assign ret_addr = pc_q + STEP_W;
  assign depth_m1 = depth_q - DW'(1);
  assign push_idx = depth_q[AW-1:0];
  assign pop_idx  = depth_m1[AW-1:0];

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    ill_set = 1'b0;
    if (!stall) begin
      case (op)
        OP_HOLD:   pc_d = pc_q;
        OP_INC:    pc_d = pc_q + STEP_W;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_JUMP:   pc_d = target;
        OP_CALL, OP_CALL_REL: begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DW'(1);
            pc_d    = (op == OP_CALL) ? target : (pc_q + offset);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            depth_d = depth_m1;
            pc_d    = stack_q[pop_idx];
          end
        end
        default:   ill_set = 1'b1;
      endcase
    end
    // A new error in the same cycle as clr_err leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
    ill_d = ill_set | (ill_q & ~clr_err);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
    end
  end

  // Stack storage is not reset; only depth decides which entries are live.
  always_ff @(posedge clock) begin
    if (push_en) stack_q[push_idx] <= ret_addr;
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign err_ill     = ill_q;

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised successor to the 16-bit accumulate-offset programme counter.
- Generalises PC width, step size and reset vector.
- Adds explicit next-PC operation select (increment, relative branch, absolute jump, call, return), stall, and an on-chip return-address stack with overflow, underflow and illegal-op flags.
- Sits in the fetch stage; drives the instruction-memory address.

Parameters:
- WIDTH, 16, PC and address width in bits.
- STEP, 1, increment applied by INC and used for the return address; unsigned, less than 2^WIDTH.
- DEPTH, 4, return-stack entries; must be at least 1.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  1 = freeze the PC, the stack and the flags this cycle.
- op  in  3  operation select (encoding below).
- offset  in  WIDTH  signed two's-complement relative displacement.
- target  in  WIDTH  absolute destination.
- clr_err  in  1  synchronous clear of the sticky error flags.
- pc  out  WIDTH  current PC, registered.
- depth  out  $clog2(DEPTH+1)  number of valid stack entries.
- stack_full  out  1  depth == DEPTH.
- stack_empty  out  1  depth == 0.
- err_ovf  out  1  sticky: CALL attempted while the stack was full.
- err_unf  out  1  sticky: RET attempted while the stack was empty.
- err_ill  out  1  sticky: reserved op seen.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately): pc=RESET_VEC, depth=0, stack_empty=1, stack_full=0, all err flags=0. Stack contents are don't-care.
- All state updates on the rising edge of clock. Single-cycle latency: the new pc is visible after the edge that samples op.
- stall=1: the op is ignored; pc, stack and depth hold. The err flags hold, except clr_err still applies.
- op encoding:
  - 000 HOLD: pc unchanged.
  - 001 INC: pc = pc + STEP.
  - 010 BRANCH: pc = pc + sign-extended offset.
  - 011 JUMP: pc = target.
  - 100 CALL: push pc+STEP; pc = target.
  - 101 RET: pop the top entry into pc.
  - 110 CALL_REL: push pc+STEP; pc = pc + offset.
  - 111 reserved: pc holds; err_ill set.
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent and raises no flag. The pushed return address also wraps.
- CALL or CALL_REL with stack_full: no push, pc holds, err_ovf set.
- RET with stack_empty: pc holds, depth stays 0, err_unf set.
- Stack is LIFO: a push writes entry[depth] and increments depth; a pop reads entry[depth-1] and decrements depth.
- stack_full and stack_empty are combinational from depth.
- clr_err and a new error in the same cycle: the new error wins, so the flag reads 1.
- Flags stay asserted until clr_err or reset.
- A reset assertion mid-sequence discards the whole stack.

Test Plan (WIDTH=16, STEP=1, DEPTH=4, RESET_VEC=0x0000):
- Reset, then 3 INC -> pc=0x0003, depth=0, stack_empty=1.
- BRANCH offset=0xFFFE from 0x0003 -> pc=0x0001. JUMP 0xFFFF, then INC -> pc=0x0000 (wrap), no flags set.
- At pc=0x0010, CALL target=0x0100 -> pc=0x0100, depth=1. Then CALL_REL offset=0x0020 -> pc=0x0120, depth=2. Then RET -> pc=0x0101. Then RET -> pc=0x0011, stack_empty=1.
- Perform 4 CALLs -> stack_full=1. A 5th CALL -> pc unchanged, depth=4, err_ovf=1. After 4 RETs, pops return in LIFO order.
- RET on an empty stack -> pc unchanged, err_unf=1. op=111 -> err_ill=1. clr_err -> both flags cleared. clr_err together with a RET on empty -> err_unf stays 1.
- stall=1 with op=CALL -> pc, depth and flags unchanged. Drop reset_n between clock edges while depth=2 -> pc=0x0000 and depth=0 immediately, before the next edge.
